// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core.
// Holds the datapath enums and the pipeline sequencing controller types.
package milano_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned REG_ADDR_W          = 5;
  localparam int unsigned LSU_TIMEOUT_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    LSU_SIZE_B,
    LSU_SIZE_H,
    LSU_SIZE_W
  } lsu_size_e;

  typedef enum logic [1:0] {
    JUMP_NONE,
    JUMP_BRANCH,
    JUMP_JAL,
    JUMP_JALR
  } jump_e;

  typedef enum logic [1:0] {
    RUN,
    WAIT_GNT,
    WAIT_RVALID
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic bubble_ex;
    logic flush_if;
    logic flush_id;
    logic lsu_timeout;
  } pipe_ctrl_out_t;

  // True when a used source operand reads the (nonzero) destination register.
  function automatic logic reg_conflict(
    input logic [REG_ADDR_W-1:0] rs1_addr,
    input logic                  rs1_used,
    input logic [REG_ADDR_W-1:0] rs2_addr,
    input logic                  rs2_used,
    input logic [REG_ADDR_W-1:0] rd_addr
  );
    return (rd_addr != '0) &&
           ((rs1_used && (rs1_addr == rd_addr)) ||
            (rs2_used && (rs2_addr == rd_addr)));
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble generation for the
// IF/ID, ID/EX and EX/MEM registers, with a bounded data-bus wait.
module pipe_ctrl
  import milano_pkg::*;
#(
  parameter int unsigned LSU_TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_lsu_req_i,
  input  logic       ex_lsu_we_i,
  input  logic       ex_jump_taken_i,
  input  logic       data_gnt_i,
  input  logic       data_rvalid_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       bubble_ex_o,
  output logic       flush_if_o,
  output logic       flush_id_o,
  output logic       lsu_timeout_o
);

  localparam int unsigned      CNT_W    = $clog2(LSU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSU_TIMEOUT - 1);

  pipe_ctrl_state_e state_q, state_d;
  logic             is_load_q, is_load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic           lsu_stall;
  logic           wait_done;
  logic           timeout;
  logic           load_use;
  pipe_ctrl_out_t ctrl;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
    end
  end

  assign load_use = ex_lsu_req_i && !ex_lsu_we_i &&
                    reg_conflict(id_rs1_addr_i, id_rs1_used_i,
                                 id_rs2_addr_i, id_rs2_used_i, ex_rd_addr_i);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    cnt_d     = cnt_q;
    lsu_stall = 1'b0;
    wait_done = 1'b0;
    timeout   = 1'b0;
    ctrl      = '0;

    unique case (state_q)
      RUN: begin
        lsu_stall = ex_lsu_req_i && !(data_gnt_i && ex_lsu_we_i);
        if (ex_lsu_req_i && !data_gnt_i) begin
          state_d   = WAIT_GNT;
          is_load_d = !ex_lsu_we_i;
        end else if (ex_lsu_req_i && data_gnt_i && !ex_lsu_we_i) begin
          state_d   = WAIT_RVALID;
          is_load_d = 1'b1;
        end
      end
      WAIT_GNT: begin
        // A granted load still has to wait for its response.
        wait_done = data_gnt_i && !is_load_q;
        lsu_stall = !wait_done;
        if (data_gnt_i) begin
          state_d = is_load_q ? WAIT_RVALID : RUN;
        end
      end
      WAIT_RVALID: begin
        wait_done = data_rvalid_i;
        lsu_stall = !data_rvalid_i;
        if (data_rvalid_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // One counter spans both wait states, bounding the whole access.
    if (state_q != RUN) begin
      if ((cnt_q == CNT_LAST) && !wait_done) begin
        timeout   = 1'b1;
        lsu_stall = 1'b0;
        state_d   = RUN;
      end
      cnt_d = (state_d == RUN) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (lsu_stall) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.stall_ex = 1'b1;
    end else if (ex_jump_taken_i) begin
      ctrl.flush_if = 1'b1;
      ctrl.flush_id = 1'b1;
    end else if (load_use) begin
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
      ctrl.bubble_ex = 1'b1;
    end
    ctrl.lsu_timeout = timeout;
  end

  // Outputs are gated by reset directly so they drop the moment rst_ni falls.
  assign stall_if_o    = rst_ni && ctrl.stall_if;
  assign stall_id_o    = rst_ni && ctrl.stall_id;
  assign stall_ex_o    = rst_ni && ctrl.stall_ex;
  assign bubble_ex_o   = rst_ni && ctrl.bubble_ex;
  assign flush_if_o    = rst_ni && ctrl.flush_if;
  assign flush_id_o    = rst_ni && ctrl.flush_id;
  assign lsu_timeout_o = rst_ni && ctrl.lsu_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vector table through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_pipe_ctrl;

  localparam logic [6:0] O_N = 7'b0000000;
  localparam logic [6:0] O_S = 7'b1110000;
  localparam logic [6:0] O_B = 7'b1101000;
  localparam logic [6:0] O_F = 7'b0000110;
  localparam logic [6:0] O_T = 7'b0000001;

  typedef struct {
    string      name;
    logic       t4;
    logic       req, we, gnt, rvalid, jmp;
    logic [4:0] rd, rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [6:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       rs1_used, rs2_used, lsu_req, lsu_we, jump_taken, gnt, rvalid;

  logic [6:0] out_def, out_t4;
  logic       d_sif, d_sid, d_sex, d_bub, d_fif, d_fid, d_tmo;
  logic       t_sif, t_sid, t_sex, t_bub, t_fif, t_fid, t_tmo;

  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       vecs[$];
  logic [6:0] exp_q[$];

  pipe_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd_addr), .ex_lsu_req_i(lsu_req), .ex_lsu_we_i(lsu_we),
    .ex_jump_taken_i(jump_taken), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .stall_if_o(d_sif), .stall_id_o(d_sid), .stall_ex_o(d_sex),
    .bubble_ex_o(d_bub), .flush_if_o(d_fif), .flush_id_o(d_fid),
    .lsu_timeout_o(d_tmo)
  );

  pipe_ctrl #(.LSU_TIMEOUT(4)) u_dut_t4 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd_addr), .ex_lsu_req_i(lsu_req), .ex_lsu_we_i(lsu_we),
    .ex_jump_taken_i(jump_taken), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .stall_if_o(t_sif), .stall_id_o(t_sid), .stall_ex_o(t_sex),
    .bubble_ex_o(t_bub), .flush_if_o(t_fif), .flush_id_o(t_fid),
    .lsu_timeout_o(t_tmo)
  );

  assign out_def = {d_sif, d_sid, d_sex, d_bub, d_fif, d_fid, d_tmo};
  assign out_t4  = {t_sif, t_sid, t_sex, t_bub, t_fif, t_fid, t_tmo};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic t4,
                              input logic req, input logic we, input logic g,
                              input logic rv, input logic j,
                              input logic [4:0] rd, input logic [4:0] r1,
                              input logic u1, input logic [4:0] r2,
                              input logic u2, input logic [6:0] exp);
    vec_t v;
    v.name = n; v.t4 = t4; v.req = req; v.we = we; v.gnt = g; v.rvalid = rv;
    v.jmp = j; v.rd = rd; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2;
    v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (sif sid sex bub fif fid tmo)",
               name, got, exp);
    end
  endtask

  task automatic drive_idle();
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_used = 0; rs2_used = 0; lsu_req = 0; lsu_we = 0;
    jump_taken = 0; gnt = 0; rvalid = 0;
  endtask

  task automatic apply(input vec_t v);
    logic [6:0] e;
    @(negedge clk);
    rs1_addr = v.rs1; rs2_addr = v.rs2; rd_addr = v.rd;
    rs1_used = v.u1; rs2_used = v.u2; lsu_req = v.req; lsu_we = v.we;
    jump_taken = v.jmp; gnt = v.gnt; rvalid = v.rvalid;
    exp_q.push_back(v.exp);
    #2;
    e = exp_q.pop_front();
    check(v.name, v.t4 ? out_t4 : out_def, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #2;
    check("rst_def", out_def, O_N);
    check("rst_t4", out_t4, O_N);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    do_reset();

    // Default-timeout controller: stores, loads, hazards, jumps.
    vecs.push_back(mk("idle",        0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("st_gnt",      0, 1,1,1,0,0, 5,5,1,5,1, O_N));
    vecs.push_back(mk("st_gnt_run",  0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("ld_req",      0, 1,0,0,0,0, 7,3,1,4,0, O_S));
    vecs.push_back(mk("ld_wgnt",     0, 1,0,0,0,0, 7,3,1,4,0, O_S));
    vecs.push_back(mk("ld_gnt",      0, 1,0,1,0,0, 7,3,1,4,0, O_S));
    vecs.push_back(mk("ld_wrv1",     0, 1,0,0,0,0, 7,3,1,4,0, O_S));
    vecs.push_back(mk("ld_wrv2",     0, 1,0,0,0,0, 7,3,1,4,0, O_S));
    vecs.push_back(mk("ld_rvalid",   0, 1,0,0,1,0, 7,3,1,4,0, O_N));
    vecs.push_back(mk("ld_after",    0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("lu_req",      0, 1,0,1,0,0, 5,1,0,5,1, O_S));
    vecs.push_back(mk("lu_bubble",   0, 1,0,0,1,0, 5,1,0,5,1, O_B));
    vecs.push_back(mk("lu_once",     0, 0,0,0,0,0, 0,1,0,5,1, O_N));
    vecs.push_back(mk("lu_rs1_req",  0, 1,0,1,0,0, 12,12,1,0,0, O_S));
    vecs.push_back(mk("lu_rs1_bub",  0, 1,0,0,1,0, 12,12,1,0,0, O_B));
    vecs.push_back(mk("unused_req",  0, 1,0,1,0,0, 6,6,0,6,0, O_S));
    vecs.push_back(mk("unused_rv",   0, 1,0,0,1,0, 6,6,0,6,0, O_N));
    vecs.push_back(mk("x0_req",      0, 1,0,1,0,0, 0,0,1,0,1, O_S));
    vecs.push_back(mk("x0_rvalid",   0, 1,0,0,1,0, 0,0,1,0,1, O_N));
    vecs.push_back(mk("jl_req",      0, 1,0,1,0,0, 9,9,1,0,0, O_S));
    vecs.push_back(mk("jl_flush",    0, 1,0,0,1,1, 9,9,1,0,0, O_F));
    vecs.push_back(mk("jmp_run",     0, 0,0,0,0,1, 0,0,0,0,0, O_F));
    vecs.push_back(mk("jmp_stall",   0, 1,0,0,0,1, 3,0,0,0,0, O_S));
    vecs.push_back(mk("jmp_wgnt",    0, 1,0,1,0,1, 3,0,0,0,0, O_S));
    vecs.push_back(mk("jmp_wrv",     0, 1,0,0,1,0, 3,0,0,0,0, O_N));
    vecs.push_back(mk("st_req",      0, 1,1,0,0,0, 2,2,1,0,0, O_S));
    vecs.push_back(mk("st_rv_ign",   0, 1,1,0,1,0, 2,2,1,0,0, O_S));
    vecs.push_back(mk("st_gnt_late", 0, 1,1,1,0,0, 2,2,1,0,0, O_N));
    vecs.push_back(mk("st_done",     0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("rv_run",      0, 0,0,0,1,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("rv_run2",     0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    run_vecs();

    // LSU_TIMEOUT=4 controller: timeout bound and counter restart.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      vecs.push_back(mk("tm_req", 1, 1,0,0,0,0, 8,1,0,1,0, O_S));
      for (int k = 0; k < 3; k++)
        vecs.push_back(mk("tm_wait", 1, 1,0,0,0,0, 8,1,0,1,0, O_S));
      vecs.push_back(mk("tm_out",  1, 1,0,0,0,0, 8,1,0,1,0, O_T));
      vecs.push_back(mk("tm_idle", 1, 0,0,0,0,0, 0,0,0,0,0, O_N));
    end
    vecs.push_back(mk("tx_req",  1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tx_gnt",  1, 1,0,1,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tx_wrv1", 1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tx_wrv2", 1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tx_out",  1, 1,0,0,0,0, 8,1,0,1,0, O_T));
    vecs.push_back(mk("tc_req",  1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tc_w1",   1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tc_w2",   1, 1,0,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tc_gnt",  1, 1,0,1,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("tc_rv",   1, 1,0,0,1,0, 8,1,0,1,0, O_N));
    vecs.push_back(mk("tc_idle", 1, 0,0,0,0,0, 0,0,0,0,0, O_N));
    vecs.push_back(mk("ts_req",  1, 1,1,0,0,0, 8,1,0,1,0, O_S));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("ts_wait", 1, 1,1,0,0,0, 8,1,0,1,0, O_S));
    vecs.push_back(mk("ts_out",  1, 1,1,0,0,0, 8,1,0,1,0, O_T));
    run_vecs();

    // Reset pulsed asynchronously while waiting for rvalid.
    do_reset();
    apply(mk("rw_req",  0, 1,0,1,0,0, 4,0,0,0,0, O_S));
    apply(mk("rw_wait", 0, 1,0,0,0,0, 4,0,0,0,0, O_S));
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_def", out_def, O_N);
    check("rst_async_t4", out_t4, O_N);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(mk("rw_run",      0, 0,0,0,0,0, 0,0,0,0,0, O_N));
    apply(mk("rw_late_rv",  0, 0,0,0,1,0, 0,0,0,0,0, O_N));
    apply(mk("rw_st_gnt",   0, 1,1,1,0,0, 4,0,0,0,0, O_N));
    apply(mk("rw_ld_req",   0, 1,0,0,0,0, 4,0,0,0,0, O_S));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the milano core. Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their stall, flush and bubble controls. Three sources drive it:
- Decoder register addresses in ID.
- EX-stage load/store and jump status.
- The data-memory grant/rvalid handshake.

It also enforces a bounded wait on the data bus and reports a timeout.

## Interface
Parameters:
- LSU_TIMEOUT, default 64: maximum cycles spent in the LSU wait states before forced release. Legal range is ≥2.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  rs1 address of the instruction in ID
- id_rs2_addr_i  in  5  rs2 address of the instruction in ID
- id_rs1_used_i  in  1  instruction in ID reads rs1
- id_rs2_used_i  in  1  instruction in ID reads rs2
- ex_rd_addr_i  in  5  destination register of the instruction in EX
- ex_lsu_req_i  in  1  instruction in EX is a load/store
- ex_lsu_we_i  in  1  EX load/store is a store
- ex_jump_taken_i  in  1  branch/JAL/JALR in EX resolved taken
- data_gnt_i  in  1  data bus grant
- data_rvalid_i  in  1  data bus read response valid
- stall_if_o  out  1  hold PC and IF/ID
- stall_id_o  out  1  hold ID/EX
- stall_ex_o  out  1  hold EX/MEM
- bubble_ex_o  out  1  load ID/EX with a NOP (rd_wr_en=0, lsu_req=0, JUMP_NONE)
- flush_if_o  out  1  invalidate IF/ID
- flush_id_o  out  1  invalidate ID/EX
- lsu_timeout_o  out  1  one-cycle pulse on wait timeout

## Operation
Registered state:
- FSM state: RUN, WAIT_GNT, WAIT_RVALID.
- is_load flag.
- Wait counter, width $clog2(LSU_TIMEOUT+1).

Reset (rst_ni low): state=RUN, is_load=0, counter=0. Every output is forced to 0 while rst_ni is low.

Define lsu_stall:
- RUN: ex_lsu_req_i & ~(data_gnt_i & ex_lsu_we_i).
- WAIT_GNT: ~(data_gnt_i & ~is_load).
- WAIT_RVALID: ~data_rvalid_i.
- In all states, lsu_stall is 0 in the cycle lsu_timeout_o is high.

When lsu_stall=1: stall_if_o = stall_id_o = stall_ex_o = 1. Flush and bubble are suppressed.

Transitions:
- RUN, ex_lsu_req_i & ~data_gnt_i → WAIT_GNT, with is_load ← ~ex_lsu_we_i.
- RUN, ex_lsu_req_i & data_gnt_i & ~ex_lsu_we_i → WAIT_RVALID, is_load←1.
- RUN, store granted same cycle → stays RUN, no stall.
- WAIT_GNT, data_gnt_i → WAIT_RVALID if is_load, else RUN.
- WAIT_RVALID, data_rvalid_i → RUN.
- Any wait state, counter == LSU_TIMEOUT-1 with no completing event → RUN. lsu_timeout_o pulses that cycle and the stall is released; the pipeline advances with undefined load data.

Counter behaviour:
- Increments every cycle in WAIT_GNT/WAIT_RVALID.
- Clears on entry to RUN.
- Continues counting across WAIT_GNT→WAIT_RVALID, so the whole access is bounded.

Bus rule: rvalid never arrives in the same cycle as its gnt. rvalid seen in RUN or WAIT_GNT is ignored.

Load-use hazard, evaluated only when lsu_stall=0. A hazard exists when all of the following hold:
- ex_lsu_req_i & ~ex_lsu_we_i
- ex_rd_addr_i≠0
- ((id_rs1_used_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i==ex_rd_addr_i))

On a hazard: stall_if_o=1, stall_id_o=1, bubble_ex_o=1 for exactly one cycle. It does not repeat, because the bubble replaces EX.

Taken jump (lsu_stall=0 & ex_jump_taken_i):
- flush_if_o=1 and flush_id_o=1 for one cycle.
- Takes priority over load-use; bubble_ex_o is forced to 0.

Priority, highest first: reset > lsu_stall > jump flush > load-use > none.

## Timing
- All outputs are combinational from the current state and inputs; state updates on the rising edge of clk_i.
- Store granted in the request cycle: zero stall cycles.
- Load with gnt in cycle N and rvalid in cycle N+k: stall asserted in cycles N..N+k-1, released in N+k.
- Load-use costs exactly 1 cycle, on top of any LSU wait.
- Timeout: stall is released in the LSU_TIMEOUT-th wait cycle, counting the first stalled cycle after the request cycle as 1.
- Reset asserted mid-wait: state returns to RUN immediately (asynchronously), the counter clears, and nothing is pulsed.

## Structure
- pipe_ctrl_state_e (RUN, WAIT_GNT, WAIT_RVALID) goes in milano_pkg, alongside the existing alu/lsu/jump enums.
- LSU_TIMEOUT_DEFAULT goes in milano_pkg.
- No sub-module; a single always_ff for state, is_load and counter, plus one always_comb for outputs and next state.

## Test plan
- Store to bus with data_gnt_i=1 in the same cycle: all outputs 0, state stays RUN.
- Load, gnt delayed 2 cycles, rvalid 3 cycles after gnt: stall_if/id/ex high for 5 cycles, then low; no bubble unless a hazard exists.
- Load x5 in EX, ID reads rs2=x5 with id_rs2_used_i=1: bubble_ex_o, stall_if_o, stall_id_o high for 1 cycle. Repeat with rd=x0: no bubble.
- ex_jump_taken_i=1 together with an ID instruction matching the EX rd: flush_if_o=flush_id_o=1 and bubble_ex_o=0.
- LSU_TIMEOUT=4, load with no gnt: stall for 3 cycles, lsu_timeout_o pulses in the 4th with stall low; state is RUN and the counter is 0 afterwards.
- rst_ni pulsed low during WAIT_RVALID: outputs go to 0 asynchronously; after release, a late rvalid is ignored and the controller is in RUN.
